sub_share_arbiter: RTL

//  Shares one multi-cycle staged subtractor (start/done engine, SIZE-bit operands, SIZE+1-bit result)

---
 rtl/sub_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing one start/done subtractor engine among NREQ requesters.
// Define SUB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
module sub_share_arbiter #(
    parameter  int NREQ = 4,
    parameter  int SIZE = 896,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ack,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [SIZE:0]        resp_result,
    output logic                 busy,
    output logic                 eng_start,
    output logic [SIZE-1:0]      eng_a,
    output logic [SIZE-1:0]      eng_b,
    input  logic [SIZE:0]        eng_result,
    input  logic                 eng_done
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] win;
    logic           win_found;

`ifdef SUB_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win       = '0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win       = IDW'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps; the first set bit found wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[(int'(rr_ptr) + i) % NREQ]) begin
                win       = IDW'((int'(rr_ptr) + i) % NREQ);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            req_ack     <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            busy        <= 1'b0;
            eng_start   <= 1'b0;
            eng_a       <= '0;
            eng_b       <= '0;
`ifndef SUB_ARB_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low with non-blocking assignments; the case below raises them for one cycle.
            req_ack    <= '0;
            eng_start  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && eng_done) begin
                        eng_a        <= req_a[win*SIZE +: SIZE];
                        eng_b        <= req_b[win*SIZE +: SIZE];
                        req_ack      <= NREQ'(1) << win;
                        eng_start    <= 1'b1;
                        owner        <= win;
                        busy         <= 1'b1;
                        state        <= ISSUE;
`ifndef SUB_ARB_FIXED_PRIO_EN
                        rr_ptr       <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                ISSUE: state <= WAIT_LOW;
                // The engine may still show done=1 right after start; wait for it to drop first.
                WAIT_LOW: begin
                    if (!eng_done) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (eng_done) begin
                        resp_result <= eng_result;
                        resp_id     <= owner;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
